enable_register: RTL and testbench

Generic N-bit storage register with synchronous reset and write enable. It is the basic state element of the SIMD AES datapath, used for pipeline stage registers, the program counter and other architectural state. Q updates only on a rising clock edge, only when reset or enable is asserted.

---
 rtl/reg_pkg.sv | 13 +
 rtl/reg_bit_cell.sv | 20 ++
 rtl/enable_register.sv | 65 ++++++
 tb/tb_enable_register.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// Shared types and helpers for the enable_register storage element.
// The parity helper is only referenced when REG_PARITY_EN is defined.
package reg_pkg;

  localparam int REG_DEFAULT_W = 32;

  typedef logic [REG_DEFAULT_W-1:0] word_t;

  function automatic logic word_parity(input word_t w);
    return ^w;
  endfunction

endpackage

// File: rtl/reg_bit_cell.sv
// One storage flop with synchronous reset taking priority over write enable.
module reg_bit_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/enable_register.sv
// N-bit register with synchronous reset and write enable built from reg_bit_cell.
// Optional registered even-parity output Q_par is enabled by REG_PARITY_EN.
module enable_register
  import reg_pkg::*;
#(
  parameter int           N       = 32,
  parameter logic [N-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] D,
  output logic [N-1:0] Q
`ifdef REG_PARITY_EN
  ,
  output logic         Q_par
`endif
);

  for (genvar i = 0; i < N; i++) begin : g_bit
    reg_bit_cell #(
      .RST_VAL(RST_VAL[i])
    ) u_cell (
      .clk(clk),
      .rst(rst),
      .en (en),
      .d  (D[i]),
      .q  (Q[i])
    );
  end

`ifdef REG_PARITY_EN
  // Parity is folded word by word so any N works with the fixed-width helper.
  localparam int CHUNKS = (N + REG_DEFAULT_W - 1) / REG_DEFAULT_W;
  typedef logic [CHUNKS*REG_DEFAULT_W-1:0] pad_t;

  function automatic logic pad_parity(input pad_t v);
    logic p;
    p = 1'b0;
    for (int c = 0; c < CHUNKS; c++) begin
      p = p ^ word_parity(v[c*REG_DEFAULT_W +: REG_DEFAULT_W]);
    end
    return p;
  endfunction

  localparam logic RST_PAR = pad_parity(pad_t'(RST_VAL));

  logic d_par;

  always_comb begin
    d_par = pad_parity(pad_t'(D));
  end

  reg_bit_cell #(
    .RST_VAL(RST_PAR)
  ) u_par_cell (
    .clk(clk),
    .rst(rst),
    .en (en),
    .d  (d_par),
    .q  (Q_par)
  );
`endif

endmodule

// File: tb/tb_enable_register.sv
// Directed scoreboard bench for enable_register: a 32-bit default instance and
// an 8-bit instance with a non-zero reset value, driven from the same controls.
`timescale 1ps/1ps
module tb_enable_register;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [31:0] d   = '0;
  logic [31:0] q;
  logic [7:0]  q8;
`ifdef REG_PARITY_EN
  logic        q_par;
  logic        q8_par;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] q;
    logic [7:0]  q8;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_q;
  logic [7:0]  m_q8;

  always #50 clk = ~clk;

  enable_register dut (
    .clk(clk),
    .rst(rst),
    .en (en),
    .D  (d),
    .Q  (q)
`ifdef REG_PARITY_EN
    ,
    .Q_par(q_par)
`endif
  );

  enable_register #(
    .N      (8),
    .RST_VAL(8'hA5)
  ) dut8 (
    .clk(clk),
    .rst(rst),
    .en (en),
    .D  (d[7:0]),
    .Q  (q8)
`ifdef REG_PARITY_EN
    ,
    .Q_par(q8_par)
`endif
  );

  task automatic check_out();
    exp_t x;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty observed=0 expected>=1 entries");
      return;
    end
    x = sb.pop_front();
    checks++;
    assert (q === x.q) else begin
      failures++;
      $error("FAIL %s Q observed=%h expected=%h", x.tag, q, x.q);
    end
    checks++;
    assert (q8 === x.q8) else begin
      failures++;
      $error("FAIL %s Q8 observed=%h expected=%h", x.tag, q8, x.q8);
    end
`ifdef REG_PARITY_EN
    checks++;
    assert (q_par === ^x.q) else begin
      failures++;
      $error("FAIL %s Q_par observed=%b expected=%b", x.tag, q_par, ^x.q);
    end
    checks++;
    assert (q8_par === ^x.q8) else begin
      failures++;
      $error("FAIL %s Q8_par observed=%b expected=%b", x.tag, q8_par, ^x.q8);
    end
`endif
  endtask

  // Drive one cycle at the falling edge, predict, then compare just after the rising edge.
  task automatic step(input logic r, input logic e, input logic [31:0] dv, input string tag);
    exp_t x;
    @(negedge clk);
    rst = r;
    en  = e;
    d   = dv;
    if (r) begin
      m_q  = 32'h0;
      m_q8 = 8'hA5;
    end else if (e) begin
      m_q  = dv;
      m_q8 = dv[7:0];
    end
    x.tag = tag;
    x.q   = m_q;
    x.q8  = m_q8;
    sb.push_back(x);
    @(posedge clk);
    #1;
    // Input wiggles between edges must not reach Q.
    d   = ~dv;
    en  = ~e;
    rst = ~r;
    #10;
    rst = r;
    en  = e;
    d   = dv;
    check_out();
  endtask

  task automatic step2(input logic r, input logic e, input logic [31:0] dv, input string tag);
    step(r, e, dv, tag);
    step(r, e, dv, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_q  = 'x;
    m_q8 = 'x;

    step2(1'b1, 1'b0, 32'h0000_0000, "reset");

    step2(1'b0, 1'b0, 32'h0001_1111, "load_gated");
    step2(1'b0, 1'b1, 32'h0001_1111, "load");

    step2(1'b0, 1'b1, 32'h000A_AAAA, "hold_load");
    step2(1'b0, 1'b0, 32'h000A_AAAA, "hold");

    step2(1'b1, 1'b1, 32'h0004_4444, "rst_priority");
    step2(1'b0, 1'b1, 32'h0004_4444, "rst_release");

    step(1'b0, 1'b1, 32'h0007_7777, "follow_a");
    step(1'b0, 1'b1, 32'h0002_2222, "follow_b");
    step2(1'b0, 1'b0, 32'h000E_EEEE, "hold_after_follow");
    step2(1'b0, 1'b0, 32'h0000_0000, "hold_zero_d");

    step2(1'b0, 1'b1, 32'h0000_0007, "par_odd");
    step2(1'b0, 1'b1, 32'h0000_0003, "par_even");
    step2(1'b1, 1'b0, 32'h0000_0000, "par_reset");

    for (int i = 0; i < 24; i++) begin
      step(($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1, $urandom, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
